dbus_arbiter: RTL and testbench

//  Shares the single data bus between two requesters: port C (CPU M-stage) and port D (DMA/debug master).

---
 rtl/dbus_arbiter.sv | 154 +++++++++++++++
 tb/tb_dbus_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// Two-port data bus arbiter: CPU (C) vs DMA/debug (D), with TC1/TC2/memory decode.
// Define ARB_ERR_EN to flag addresses above MEM_TOP (outside the TC windows) as errors.
module dbus_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter logic [31:0] MEM_TOP    = 32'h2fff
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_byteen,
    output logic        c_ack,
    output logic [31:0] c_rdata,
    output logic        c_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteen,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_rdata,
    output logic [29:0] tc_addr,
    output logic        tc1_we,
    output logic        tc2_we,
    input  logic [31:0] tc1_dout,
    input  logic [31:0] tc2_dout
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state, next_state;
    logic [31:0] lat_addr, lat_wdata;
    logic [3:0]  lat_byteen;
    logic        lat_is_d;
    logic [3:0]  streak;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        any_req, d_wins;
    logic        hit_tc1, hit_tc2, addr_err, is_write;
    logic [31:0] sel_rdata;

    // D only beats a simultaneous CPU request once the CPU has won STARVE_MAX times in a row.
    assign any_req = c_req | d_req;
    assign d_wins  = d_req & (~c_req | (streak == STARVE_LIM));

    assign hit_tc1  = (lat_addr >= 32'h7f00) && (lat_addr <= 32'h7f0b);
    assign hit_tc2  = (lat_addr >= 32'h7f10) && (lat_addr <= 32'h7f1b);
    assign is_write = |lat_byteen;
`ifdef ARB_ERR_EN
    assign addr_err = ~hit_tc1 & ~hit_tc2 & (lat_addr > MEM_TOP);
`else
    assign addr_err = 1'b0;
`endif

    assign sel_rdata = hit_tc1 ? tc1_dout : (hit_tc2 ? tc2_dout : m_data_rdata);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        m_data_byteen = 4'b0000;
        tc1_we        = 1'b0;
        tc2_we        = 1'b0;
        c_ack         = 1'b0;
        d_ack         = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                next_state = DONE;
                if (hit_tc1) begin
                    tc1_we = is_write;
                end else if (hit_tc2) begin
                    tc2_we = is_write;
                end else if (!addr_err) begin
                    m_data_byteen = lat_byteen;
                end
            end
            DONE: begin
                next_state = IDLE;
                c_ack      = ~lat_is_d;
                d_ack      = lat_is_d;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            lat_byteen <= 4'h0;
            lat_is_d   <= 1'b0;
        end else if (state == IDLE && any_req) begin
            lat_addr   <= d_wins ? d_addr   : c_addr;
            lat_wdata  <= d_wins ? d_wdata  : c_wdata;
            lat_byteen <= d_wins ? d_byteen : c_byteen;
            lat_is_d   <= d_wins;
        end
    end

    // Streak only counts CPU wins that actually made D wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak <= 4'h0;
        end else if (state == IDLE) begin
            if (!d_req || d_wins) begin
                streak <= 4'h0;
            end else if (streak < STARVE_LIM) begin
                streak <= streak + 4'h1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (state == ACCESS) begin
            rdata_q <= (is_write || addr_err) ? 32'h0 : sel_rdata;
            err_q   <= addr_err;
        end
    end

    assign c_rdata      = c_ack ? rdata_q : 32'h0;
    assign d_rdata      = d_ack ? rdata_q : 32'h0;
    assign c_err        = c_ack & err_q;
    assign d_err        = d_ack & err_q;
    assign m_data_addr  = lat_addr;
    assign m_data_wdata = lat_wdata;
    assign tc_addr      = lat_addr[31:2];

endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomized bench for dbus_arbiter against a transaction-level reference model.
// Honours ARB_ERR_EN the same way the design does.
module tb_dbus_arbiter;

    localparam int STARVE = 4;
    localparam logic [31:0] MEM_TOP = 32'h2fff;
`ifdef ARB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, d_req;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic [3:0]  c_byteen, d_byteen;
    logic        c_ack, d_ack, c_err, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic [31:0] m_data_addr, m_data_wdata, m_data_rdata;
    logic [3:0]  m_data_byteen;
    logic [29:0] tc_addr;
    logic        tc1_we, tc2_we;
    logic [31:0] tc1_dout, tc2_dout;

    int checks = 0;
    int failures = 0;

    // Model of the transaction in flight: age counts cycles since the grant edge.
    int          age = 0;
    int          streak = 0;
    bit          e_is_d;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;
    bit          e_err;
    bit          c_pend = 0, d_pend = 0;
    int          gen_pct = 0;
    int          grants[$];

    dbus_arbiter #(.STARVE_MAX(STARVE), .MEM_TOP(MEM_TOP)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_addr(c_addr), .c_wdata(c_wdata), .c_byteen(c_byteen),
        .c_ack(c_ack), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_byteen(d_byteen),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_data_rdata(m_data_rdata),
        .tc_addr(tc_addr), .tc1_we(tc1_we), .tc2_we(tc2_we),
        .tc1_dout(tc1_dout), .tc2_dout(tc2_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h5a5a0000;
    endfunction

    assign m_data_rdata = mem_fn(m_data_addr);

    function automatic int target(input logic [31:0] a);
        if (a >= 32'h7f00 && a <= 32'h7f0b) return 1;
        if (a >= 32'h7f10 && a <= 32'h7f1b) return 2;
        return 0;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic new_txn(output logic [31:0] a, output logic [31:0] w, output logic [3:0] be);
        logic [31:0] edges [8];
        edges = '{32'h7efc, 32'h7f0c, 32'h7f0b, 32'h7f1b, 32'h7f1c, 32'h2ffc, 32'h2fff, 32'h3000};
        case ($urandom_range(0, 5))
            0: a = 32'($urandom_range(0, 32'h2fff)) & 32'hffff_fffc;
            1: a = 32'h7f00 + 32'(4 * $urandom_range(0, 2));
            2: a = 32'h7f10 + 32'(4 * $urandom_range(0, 2));
            3: a = edges[$urandom_range(0, 7)];
            4: a = 32'h9000;
            default: a = $urandom;
        endcase
        w  = $urandom;
        be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    endtask

    // Advance the model across the coming edge, using the inputs present before it.
    task automatic model_edge;
        case (age)
            0: begin
                if (c_req || d_req) begin
                    if (d_req && (!c_req || streak == STARVE)) begin
                        e_is_d = 1; e_addr = d_addr; e_wdata = d_wdata; e_be = d_byteen;
                        streak = 0;
                    end else begin
                        e_is_d = 0; e_addr = c_addr; e_wdata = c_wdata; e_be = c_byteen;
                        streak = d_req ? ((streak < STARVE) ? streak + 1 : STARVE) : 0;
                    end
                    e_err = ERR_EN && target(e_addr) == 0 && e_addr > MEM_TOP;
                    age = 1;
                end else begin
                    streak = 0;
                end
            end
            1: begin
                if (e_be != 0 || e_err) e_rdata = 0;
                else if (target(e_addr) == 1) e_rdata = tc1_dout;
                else if (target(e_addr) == 2) e_rdata = tc2_dout;
                else e_rdata = mem_fn(e_addr);
                age = 2;
            end
            default: age = 0;
        endcase
    endtask

    task automatic check_cycle;
        bit strobe;
        int t;
        strobe = (age == 1);
        t = target(e_addr);
        check_output("c_ack", 32'(c_ack), 32'(age == 2 && !e_is_d));
        check_output("d_ack", 32'(d_ack), 32'(age == 2 && e_is_d));
        if (age == 2 && e_is_d) begin
            check_output("d_rdata", d_rdata, e_rdata);
            check_output("d_err", 32'(d_err), 32'(e_err));
        end else if (age == 2) begin
            check_output("c_rdata", c_rdata, e_rdata);
            check_output("c_err", 32'(c_err), 32'(e_err));
        end
        check_output("m_data_byteen", 32'(m_data_byteen),
                     32'((strobe && t == 0 && !e_err) ? e_be : 4'h0));
        check_output("tc1_we", 32'(tc1_we), 32'(strobe && t == 1 && e_be != 0));
        check_output("tc2_we", 32'(tc2_we), 32'(strobe && t == 2 && e_be != 0));
        if (strobe) begin
            check_output("m_data_addr", m_data_addr, e_addr);
            check_output("tc_addr", 32'(tc_addr), 32'(e_addr[31:2]));
            check_output("m_data_wdata", m_data_wdata, e_wdata);
        end
        if (c_ack) grants.push_back(0);
        if (d_ack) grants.push_back(1);
    endtask

    // Requesters hold their transaction until the model says it was acknowledged.
    task automatic apply_stimulus;
        if (age == 2 && !e_is_d) c_pend = 0;
        if (age == 2 && e_is_d)  d_pend = 0;
        if (!c_pend && $urandom_range(0, 99) < gen_pct) begin
            new_txn(c_addr, c_wdata, c_byteen);
            c_pend = 1;
        end
        if (!d_pend && $urandom_range(0, 99) < gen_pct) begin
            new_txn(d_addr, d_wdata, d_byteen);
            d_pend = 1;
        end
        c_req = c_pend;
        d_req = d_pend;
        tc1_dout = $urandom;
        tc2_dout = $urandom;
    endtask

    task automatic run_cycle;
        model_edge();
        @(posedge clk);
        #1;
        check_cycle();
        apply_stimulus();
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_c_ack"}, 32'(c_ack), 0);
        check_output({tag, "_d_ack"}, 32'(d_ack), 0);
        check_output({tag, "_c_rdata"}, c_rdata, 0);
        check_output({tag, "_d_err"}, 32'(d_err), 0);
        check_output({tag, "_byteen"}, 32'(m_data_byteen), 0);
        check_output({tag, "_m_addr"}, m_data_addr, 0);
        check_output({tag, "_m_wdata"}, m_data_wdata, 0);
        check_output({tag, "_tc_addr"}, 32'(tc_addr), 0);
        check_output({tag, "_tc_we"}, 32'({tc1_we, tc2_we}), 0);
    endtask

    task automatic drain;
        gen_pct = 0;
        for (int i = 0; i < 20 && (c_pend || d_pend || age != 0); i++) run_cycle();
        check_output("drain_idle", 32'(c_pend || d_pend), 0);
    endtask

    initial begin
        reset = 1'b1;
        c_req = 0; d_req = 0;
        c_addr = 0; c_wdata = 0; c_byteen = 0;
        d_addr = 0; d_wdata = 0; d_byteen = 0;
        tc1_dout = 0; tc2_dout = 0;
        #3;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Both ports saturated: C,C,C,C,D repeating.
        grants.delete();
        gen_pct = 100;
        apply_stimulus();
        for (int i = 0; i < 30; i++) run_cycle();
        check_output("order_len", 32'(grants.size() >= 10), 1);
        for (int i = 0; i < 10; i++)
            check_output($sformatf("order_%0d", i),
                         (i < grants.size()) ? 32'(grants[i]) : 32'hffff_ffff,
                         32'(i % 5 == 4));
        drain();

        // Reset while a D write is on the bus: nothing may be acknowledged.
        d_addr = 32'h100; d_wdata = 32'hcafef00d; d_byteen = 4'hf;
        d_pend = 1; d_req = 1;
        run_cycle();
        reset = 1'b1;
        #1;
        age = 0; streak = 0; d_pend = 0; d_req = 0;
        check_all_zero("abort");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) run_cycle();

        // Random traffic on both ports.
        gen_pct = 50;
        for (int i = 0; i < 3000; i++) run_cycle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
